// File: rtl/fp_norm_lzc_pipe.sv
// fp_norm_lzc_pipe: two-stage normalizer for unnormalized FP intermediates.
// Stage 1 counts leading zeros of the mantissa from four byte-wide counters.
// Stage 2 shifts the mantissa left and lowers the exponent. The shift is
// clamped so the exponent never goes below 1, which produces denormals.
//
// Handshake: a beat moves on a rising edge when valid and ready are both high.
// A single global enable (en = ~out_valid | out_ready) advances both stages
// together and is driven out as in_ready. A held output is never overwritten.
module fp_norm_lzc_pipe #(
    parameter int EW = 10,
    parameter int MW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp,
    input  logic [MW-1:0] in_mant,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [EW-1:0] out_exp,
    output logic [MW-1:0] out_mant,
    output logic          out_zero,
    output logic          out_denorm
);

    // Byte leading-zero counter: returns {nonzero, count[2:0]}.
    function automatic logic [3:0] lzc8(input logic [7:0] b);
        logic [2:0] c;
        logic       found;
        c     = 3'd0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!found && b[i]) begin
                c     = 3'(7 - i);
                found = 1'b1;
            end
        end
        return {found, c};
    endfunction

    logic en;

    logic          s1_valid_q;
    logic          s1_sign_q;
    logic [EW-1:0] s1_exp_q;
    logic [MW-1:0] s1_mant_q;
    logic [5:0]    s1_cnt_q;
    logic          s1_zero_q;

    logic [5:0]    cnt_d;
    logic          zero_d;

    logic          out_valid_q;
    logic          out_sign_q;
    logic [EW-1:0] out_exp_q;
    logic [MW-1:0] out_mant_q;
    logic          out_zero_q;
    logic          out_denorm_q;

    logic [EW-1:0] out_exp_d;
    logic [MW-1:0] out_mant_d;
    logic          out_denorm_d;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    // Leading-zero count of in_mant: byte counters combined pairwise, then halves.
    always_comb begin
        logic [3:0] l3, l2, l1, l0;
        logic       v_hi, v_lo;
        logic [3:0] c_hi, c_lo;
        logic [4:0] c_full;
        l3     = lzc8(in_mant[31:24]);
        l2     = lzc8(in_mant[23:16]);
        l1     = lzc8(in_mant[15:8]);
        l0     = lzc8(in_mant[7:0]);
        v_hi   = l3[3] | l2[3];
        v_lo   = l1[3] | l0[3];
        c_hi   = l3[3] ? {1'b0, l3[2:0]} : {1'b1, l2[2:0]};
        c_lo   = l1[3] ? {1'b0, l1[2:0]} : {1'b1, l0[2:0]};
        c_full = v_hi ? {1'b0, c_hi} : {1'b1, c_lo};
        zero_d = ~(v_hi | v_lo);
        cnt_d  = zero_d ? 6'd32 : {1'b0, c_full};
    end

    // Stage 1 register: capture the beat and its leading-zero count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s1_cnt_q   <= '0;
            s1_zero_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= in_sign;
            s1_exp_q   <= in_exp;
            s1_mant_q  <= in_mant;
            s1_cnt_q   <= cnt_d;
            s1_zero_q  <= zero_d;
        end
    end

    // Clamped shift amount: never lower the exponent below 1.
    always_comb begin
        logic signed [EW:0] exp_x;
        logic [EW:0]        lim;
        logic [EW:0]        cnt_x;
        logic [5:0]         sh;
        exp_x = {s1_exp_q[EW-1], s1_exp_q};
        lim   = (exp_x > 1) ? (EW+1)'(exp_x - (EW+1)'(1)) : '0;
        cnt_x = (EW+1)'(s1_cnt_q);
        if (s1_zero_q) begin
            sh = 6'd0;
        end else if (lim < cnt_x) begin
            sh = lim[5:0];
        end else begin
            sh = s1_cnt_q;
        end
        out_mant_d   = s1_mant_q << sh;
        out_exp_d    = s1_zero_q ? '0 : (s1_exp_q - EW'(sh));
        out_denorm_d = ~s1_zero_q & ~out_mant_d[MW-1];
    end

    // Stage 2 register: normalized result held until the consumer takes it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_sign_q   <= 1'b0;
            out_exp_q    <= '0;
            out_mant_q   <= '0;
            out_zero_q   <= 1'b0;
            out_denorm_q <= 1'b0;
        end else if (en) begin
            out_valid_q  <= s1_valid_q;
            out_sign_q   <= s1_sign_q;
            out_exp_q    <= out_exp_d;
            out_mant_q   <= out_mant_d;
            out_zero_q   <= s1_zero_q;
            out_denorm_q <= out_denorm_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sign   = out_sign_q;
    assign out_exp    = out_exp_q;
    assign out_mant   = out_mant_q;
    assign out_zero   = out_zero_q;
    assign out_denorm = out_denorm_q;

endmodule

// File: tb/tb_fp_norm_lzc_pipe.sv
// Bench for fp_norm_lzc_pipe: directed steps, one cycle per step, with a
// behavioural normalizer feeding an expected-result queue.
module tb_fp_norm_lzc_pipe;

    localparam int EW = 10;
    localparam int MW = 32;
    localparam int RW = 1 + EW + MW + 2;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [EW-1:0] in_exp;
    logic [MW-1:0] in_mant;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [MW-1:0] out_mant;
    logic          out_zero;
    logic          out_denorm;

    logic [RW-1:0] exp_q[$];
    int            checks;
    int            errors;
    int            cyc;
    int            stall_cnt;

    fp_norm_lzc_pipe #(.EW(EW), .MW(MW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign   (out_sign),
        .out_exp    (out_exp),
        .out_mant   (out_mant),
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference normalizer: shift one bit at a time while the exponent allows.
    function automatic logic [RW-1:0] model(input logic s, input logic [EW-1:0] e,
                                            input logic [MW-1:0] m);
        int            ex;
        logic [MW-1:0] mm;
        ex = int'($signed(e));
        mm = m;
        if (m == '0) return {s, {EW{1'b0}}, {MW{1'b0}}, 1'b1, 1'b0};
        while (!mm[MW-1] && ex > 1) begin
            mm = mm << 1;
            ex = ex - 1;
        end
        return {s, EW'(ex), mm, 1'b0, ~mm[MW-1]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle: drive inputs, check the output side before the edge, then
    // record any accepted beat after the edge.
    task automatic step(input logic v, input logic s, input logic [EW-1:0] e,
                        input logic [MW-1:0] m, input logic ordy, output logic acc);
        logic [RW-1:0] obs;
        in_valid  = v;
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        out_ready = ordy;
        #1;
        acc = v & in_ready;
        if (!in_ready) stall_cnt++;
        obs = {out_sign, out_exp, out_mant, out_zero, out_denorm};
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else if (out_ready) begin
                chk("result", 64'(obs), 64'(exp_q.pop_front()));
            end else begin
                chk("stall_hold", 64'(obs), 64'(exp_q[0]));
            end
        end
        @(posedge clock);
        if (acc) exp_q.push_back(model(s, e, m));
        cyc++;
        @(negedge clock);
    endtask

    // Offer one beat until accepted (bounded), output always ready.
    task automatic send(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) step(1'b1, s, e, m, 1'b1, acc);
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic          acc;
        int            sent;
        int            first_acc;
        logic [MW-1:0] bp_mant[6];
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        stall_cnt = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_data", 64'({out_sign, out_exp, out_mant, out_zero, out_denorm}), 64'd0);
        reset = 1'b1;

        // Directed values
        send(1'b0, 10'd20, 32'h0001_0000);
        send(1'b1, 10'd7, 32'h0000_0000);
        send(1'b0, 10'd3, 32'h8000_0001);
        send(1'b0, 10'd4, 32'h0000_0100);
        send(1'b0, 10'h3FD, 32'h0000_0001);     // exp -3
        send(1'b1, 10'h200, 32'h0000_0040);     // exp -512
        send(1'b0, 10'd1, 32'h0000_0001);
        send(1'b1, 10'd2, 32'h4000_0000);
        drain();

        // Byte-boundary sweep, back to back
        for (int p = 31; p >= 0; p--) send(1'b0, 10'd100, 32'h1 << p);
        drain();

        // Latency: accepted beat visible two cycles later
        step(1'b1, 1'b0, 10'd50, 32'h0000_0300, 1'b1, acc);
        #1 chk("lat_early", 64'(out_valid), 64'd0);
        idle(1);
        #1 chk("lat_on_time", 64'(out_valid), 64'd1);
        drain();

        // Backpressure: six beats, out_ready low three cycles after first output
        for (int k = 0; k < 6; k++) bp_mant[k] = 32'h1 << $urandom_range(31, 0);
        sent      = 0;
        first_acc = -1;
        stall_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            logic ordy;
            ordy = !(first_acc >= 0 && cyc >= first_acc + 2 && cyc <= first_acc + 4);
            if (sent < 6) begin
                step(1'b1, 1'(k), 10'(20 + k), bp_mant[sent], ordy, acc);
                if (acc && first_acc < 0) first_acc = cyc - 1;
                if (acc) sent++;
            end else begin
                step(1'b0, 1'b0, '0, '0, ordy, acc);
            end
        end
        chk("bp_in_ready_low", 64'(stall_cnt), 64'd3);
        chk("bp_all_sent", 64'(sent), 64'd6);
        drain();

        // Random beats with random backpressure
        for (int k = 0; k < 30; k++) begin
            step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 10'($urandom_range(1023, 0)),
                 32'($urandom) >> $urandom_range(31, 0), 1'($urandom_range(1, 0)), acc);
        end
        drain();

        // Reset mid-stream with two beats in flight
        step(1'b1, 1'b1, 10'd9, 32'h0000_0000, 1'b1, acc);
        step(1'b1, 1'b0, 10'd12, 32'h0000_0010, 1'b1, acc);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'({out_sign, out_exp, out_mant, out_zero, out_denorm}), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        idle(4);
        step(1'b1, 1'b0, 10'd30, 32'h0004_0000, 1'b1, acc);
        chk("post_rst_accept", 64'(acc), 64'd1);
        #1 chk("post_rst_lat_early", 64'(out_valid), 64'd0);
        idle(1);
        #1 chk("post_rst_lat", 64'(out_valid), 64'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
